eth_dma_tx_reader: RTL

- Ethernet-side consumer of the debug DMA transmit buffer, clocked in the Ethernet TX domain.
- On a start command it walks a range of 32-bit words in the TX buffer, absorbing the buffer's fixed 2-cycle registered read latency.
- It checks the per-word parity bit and serialises each word MSB-byte-first onto a valid/ready byte stream toward the MAC framer.

---
 rtl/eth_dma_tx_reader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_dma_tx_reader.sv
// Ethernet-side reader of the debug DMA TX buffer: walks a word range through the
// buffer's 2-cycle read port, checks parity and streams each word MSB byte first.
module eth_dma_tx_reader #(
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 11,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              eth_tx_clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  word_cnt,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] buf_addr,
   input  logic [31:0]       buf_data,
   input  logic              buf_parity,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic              par_err
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [CNT_W-1:0]  rd_left_q, rd_left_d;
   logic [CNT_W-1:0]  wr_left_q, wr_left_d;
   logic [2:0]        pipe_v_q, pipe_v_d;
   logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d;
   logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d;
   logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [31:0]       fifo_mem [FIFO_DEPTH];
   logic [23:0]       shift_q, shift_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic              word_last_q, word_last_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic              tx_last_q, tx_last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              par_err_q, par_err_d;

   logic              issue, accept, capture, fifo_empty;
   logic              need_word, load, fifo_push, fifo_pop;
   logic [31:0]       next_word;

   // NOTE: every signal gets a default at the top so no path leaves it unassigned,
   // which is what keeps always_comb from inferring a latch.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      buf_addr_d  = buf_addr_q;
      rd_left_d   = rd_left_q;
      wr_left_d   = wr_left_q;
      fifo_wr_d   = fifo_wr_q;
      fifo_rd_d   = fifo_rd_q;
      fifo_cnt_d  = fifo_cnt_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      word_last_d = word_last_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      tx_last_d   = tx_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      par_err_d   = par_err_q;
      issue       = 1'b0;
      accept      = tx_valid_q && tx_ready;
      capture     = pipe_v_q[2];

      // The first read goes out on the start edge itself so the address appears in cycle 1.
      case (state_q)
         S_IDLE: begin
            if (start && (word_cnt != '0)) begin
               state_d    = S_RUN;
               busy_d     = 1'b1;
               par_err_d  = 1'b0;
               issue      = 1'b1;
               buf_addr_d = start_addr;
               rd_ptr_d   = start_addr + ADDR_W'(1);
               rd_left_d  = word_cnt - CNT_W'(1);
               wr_left_d  = word_cnt;
            end
         end
         S_RUN: begin
            if (rd_left_q == '0) begin
               state_d = S_FLUSH;
            end else if ((int'(fifo_cnt_q) + $countones(pipe_v_q)) < FIFO_DEPTH) begin
               issue      = 1'b1;
               buf_addr_d = rd_ptr_q;
               rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
               rd_left_d  = rd_left_q - CNT_W'(1);
            end
         end
         default: ;
      endcase

      pipe_v_d = {pipe_v_q[1:0], issue};
      if (capture && (buf_parity != ^buf_data)) par_err_d = 1'b1;

      // An empty FIFO lets the arriving word bypass straight into the serialiser.
      fifo_empty = (fifo_cnt_q == '0);
      next_word  = fifo_empty ? buf_data : fifo_mem[fifo_rd_q];
      need_word  = !tx_valid_q || (accept && (byte_idx_q == 2'd3));
      load       = need_word && (!fifo_empty || capture);
      fifo_pop   = load && !fifo_empty;
      fifo_push  = capture && !(load && fifo_empty);

      if (accept && (byte_idx_q != 2'd3)) begin
         tx_data_d  = shift_q[23:16];
         shift_d    = {shift_q[15:0], 8'h00};
         byte_idx_d = byte_idx_q + 2'd1;
         tx_last_d  = (byte_idx_q == 2'd2) && word_last_q;
      end else if (load) begin
         tx_data_d   = next_word[31:24];
         shift_d     = next_word[23:0];
         byte_idx_d  = 2'd0;
         tx_valid_d  = 1'b1;
         tx_last_d   = 1'b0;
         word_last_d = (wr_left_q == CNT_W'(1));
         wr_left_d   = wr_left_q - CNT_W'(1);
      end else if (accept) begin
         tx_valid_d = 1'b0;
         tx_last_d  = 1'b0;
      end

      if (fifo_push) fifo_wr_d = fifo_wr_q + PTR_W'(1);
      if (fifo_pop)  fifo_rd_d = fifo_rd_q + PTR_W'(1);
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
         default: ;
      endcase

      if (accept && tx_last_q) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge eth_tx_clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         rd_ptr_q    <= '0;
         buf_addr_q  <= '0;
         rd_left_q   <= '0;
         wr_left_q   <= '0;
         pipe_v_q    <= '0;
         fifo_wr_q   <= '0;
         fifo_rd_q   <= '0;
         fifo_cnt_q  <= '0;
         shift_q     <= '0;
         byte_idx_q  <= '0;
         word_last_q <= 1'b0;
         tx_data_q   <= '0;
         tx_valid_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         par_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         buf_addr_q  <= buf_addr_d;
         rd_left_q   <= rd_left_d;
         wr_left_q   <= wr_left_d;
         pipe_v_q    <= pipe_v_d;
         fifo_wr_q   <= fifo_wr_d;
         fifo_rd_q   <= fifo_rd_d;
         fifo_cnt_q  <= fifo_cnt_d;
         shift_q     <= shift_d;
         byte_idx_q  <= byte_idx_d;
         word_last_q <= word_last_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         tx_last_q   <= tx_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         par_err_q   <= par_err_d;
      end
   end

   // NOTE: the FIFO storage has no reset; occupancy is tracked by the reset counters,
   // so stale entries are never read.
   always_ff @(posedge eth_tx_clk) begin
      if (fifo_push) fifo_mem[fifo_wr_q] <= buf_data;
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign buf_addr = buf_addr_q;
   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign par_err  = par_err_q;

endmodule
